// File: rtl/alu_share_arb_if.sv
// Bundle of the two requester ports, the shared ALU port and the
// response channel of alu_share_arb.
interface alu_share_arb_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_aluc;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_aluc;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_aluc;
  logic [DATA_W-1:0] alu_s;
  logic              alu_z;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_s;
  logic              rsp_z;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_aluc, req0_a, req0_b,
    input  req1_valid, req1_aluc, req1_a, req1_b,
    input  alu_s, alu_z, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_aluc,
    output rsp_valid, rsp_id, rsp_s, rsp_z, rsp_err
  );

  modport master (
    output req0_valid, req0_aluc, req0_a, req0_b,
    output req1_valid, req1_aluc, req1_a, req1_b,
    output alu_s, alu_z, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_aluc,
    input  rsp_valid, rsp_id, rsp_s, rsp_z, rsp_err
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin share of one combinational ALU between two requesters;
// IDLE accepts, EXEC captures the result, RESP holds it for the consumer.
module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input logic           clk,
  input logic           clrn,
  alu_share_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              id_q, id_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              vld_q, vld_d;
  logic              rid_q, rid_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic              z_q, z_d;
  logic              rerr_q, rerr_d;
  logic              gnt0, gnt1;
  logic              rdy0, rdy1;
  logic [OP_W-1:0]   op_sel;

  function automatic logic legal(input logic [OP_W-1:0] op);
    case (op)
      4'b0000, 4'b1000, 4'b0111,
      4'b0110, 4'b0100, 4'b0010,
      4'b0001, 4'b0101, 4'b1101: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
  endfunction

  // last_q=1 hands a tie to requester 0
  assign gnt0   = bus.req0_valid & (~bus.req1_valid | last_q);
  assign gnt1   = bus.req1_valid & ~gnt0;
  assign op_sel = gnt1 ? bus.req1_aluc : bus.req0_aluc;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    vld_d   = vld_q;
    rid_d   = rid_q;
    s_d     = s_q;
    z_d     = z_q;
    rerr_d  = rerr_q;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    unique case (state_q)
      IDLE: begin
        rdy0 = gnt0;
        rdy1 = gnt1;
        if (gnt0 | gnt1) begin
          a_d     = gnt1 ? bus.req1_a : bus.req0_a;
          b_d     = gnt1 ? bus.req1_b : bus.req0_b;
          op_d    = op_sel;
          id_d    = gnt1;
          last_d  = gnt1;
          err_d   = ~legal(op_sel);
          state_d = EXEC;
        end
      end
      EXEC: begin
        s_d     = bus.alu_s;
        z_d     = bus.alu_z;
        rid_d   = id_q;
        rerr_d  = err_q;
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      vld_q   <= 1'b0;
      rid_q   <= 1'b0;
      s_q     <= '0;
      z_q     <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      vld_q   <= vld_d;
      rid_q   <= rid_d;
      s_q     <= s_d;
      z_q     <= z_d;
      rerr_q  <= rerr_d;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_aluc   = op_q;
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_id     = rid_q;
  assign bus.rsp_s      = s_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_err    = rerr_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a behavioural shared ALU.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_share_arb;
  logic clk;
  logic clrn;
  int   n_chk;
  int   n_fail;

  alu_share_arb_if bus ();

  alu_share_arb dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus.alu_aluc)
      4'b0000: bus.alu_s = bus.alu_a + bus.alu_b;
      4'b1000: bus.alu_s = bus.alu_a - bus.alu_b;
      4'b0111: bus.alu_s = bus.alu_a & bus.alu_b;
      4'b0110: bus.alu_s = bus.alu_a | bus.alu_b;
      4'b0100: bus.alu_s = bus.alu_a ^ bus.alu_b;
      4'b0010: bus.alu_s = bus.alu_b;
      4'b0001: bus.alu_s = bus.alu_a << bus.alu_b[4:0];
      4'b0101: bus.alu_s = bus.alu_a >> bus.alu_b[4:0];
      4'b1101: bus.alu_s = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      default: bus.alu_s = '0;
    endcase
    bus.alu_z = (bus.alu_s == '0);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input bit v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.req1_valid = v;
      bus.req1_aluc  = op;
      bus.req1_a     = a;
      bus.req1_b     = b;
    end else begin
      bus.req0_valid = v;
      bus.req0_aluc  = op;
      bus.req0_a     = a;
      bus.req0_b     = b;
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  task automatic run_op(input string tag, input bit id,
                        input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] es, input logic ez,
                        input logic ee);
    int n;
    drive(id, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!rdy(id) && n < 20) begin
      cyc();
      n++;
    end
    chk({tag, "_rdy"}, 32'(rdy(id)), 32'd1);
    cyc();
    drive(id, 1'b0, 4'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk({tag, "_alu_a"}, bus.alu_a, a);
    chk({tag, "_alu_b"}, bus.alu_b, b);
    chk({tag, "_aluc"}, 32'(bus.alu_aluc), 32'(op));
    chk({tag, "_vld_n1"}, 32'(bus.rsp_valid), 32'd0);
    cyc();
    chk({tag, "_vld_n2"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    chk({tag, "_s"}, bus.rsp_s, es);
    chk({tag, "_z"}, 32'(bus.rsp_z), 32'(ez));
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(ee));
    cyc();
    chk({tag, "_done"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clrn   = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 4'h0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 4'h0, 32'd0, 32'd0);
    #3;
    chk("rst_vld", 32'(bus.rsp_valid), 32'd0);
    chk("rst_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_s", bus.rsp_s, 32'd0);
    chk("rst_z", 32'(bus.rsp_z), 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_aluc", 32'(bus.alu_aluc), 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;

    drive(1'b0, 1'b1, 4'h0, 32'd1, 32'd2);
    drive(1'b1, 1'b1, 4'h0, 32'd10, 32'd20);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_rdy0", 32'(bus.req0_ready), 32'(k % 2 == 0));
      chk("rr_rdy1", 32'(bus.req1_ready), 32'(k % 2 == 1));
      cyc();
      chk("rr_exec", 32'(bus.rsp_valid), 32'd0);
      cyc();
      chk("rr_vld", 32'(bus.rsp_valid), 32'd1);
      chk("rr_id", 32'(bus.rsp_id), 32'(k % 2));
      chk("rr_s", bus.rsp_s, (k % 2 == 1) ? 32'd30 : 32'd3);
      cyc();
    end
    drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);

    run_op("add", 1'b0, 4'b0000, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
    run_op("sub", 1'b1, 4'b1000, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0);
    run_op("sra", 1'b1, 4'b1101, 32'h8000_0000, 32'd4,
           32'hF800_0000, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("idle_alu_a", bus.alu_a, 32'h8000_0000);
    chk("idle_alu_b", bus.alu_b, 32'd4);
    chk("idle_rsp_s", bus.rsp_s, 32'hF800_0000);

    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, 4'b0110, 32'hF0, 32'h0F);
    #1;
    chk("stall_rdy0", 32'(bus.req0_ready), 32'd1);
    cyc();
    drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 4'b0111, 32'hFF, 32'h0F);
    #1;
    chk("exec_rdy1", 32'(bus.req1_ready), 32'd0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", 32'(bus.rsp_valid), 32'd1);
      chk("stall_s", bus.rsp_s, 32'hFF);
      chk("stall_id", 32'(bus.rsp_id), 32'd0);
      chk("stall_rdy1", 32'(bus.req1_ready), 32'd0);
      cyc();
    end
    bus.rsp_ready = 1'b1;
    cyc();
    chk("stall_rel", 32'(bus.rsp_valid), 32'd0);
    chk("wait_rdy1", 32'(bus.req1_ready), 32'd1);
    cyc();
    drive(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    cyc();
    cyc();
    chk("and_id", 32'(bus.rsp_id), 32'd1);
    chk("and_s", bus.rsp_s, 32'h0F);
    cyc();

    run_op("bad", 1'b0, 4'b1111, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1);
    run_op("lui", 1'b1, 4'b0010, 32'd0, 32'h1234_5000,
           32'h1234_5000, 1'b0, 1'b0);
    run_op("xor", 1'b0, 4'b0100, 32'hFF00, 32'h0FF0,
           32'hF0F0, 1'b0, 1'b0);
    run_op("sll", 1'b0, 4'b0001, 32'd1, 32'd31,
           32'h8000_0000, 1'b0, 1'b0);
    run_op("srl", 1'b1, 4'b0101, 32'h8000_0000, 32'd31,
           32'd1, 1'b0, 1'b0);

    drive(1'b0, 1'b1, 4'b0100, 32'd3, 32'd5);
    cyc();
    drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    chk("mid_alu_a", bus.alu_a, 32'd3);
    clrn = 1'b0;
    #1;
    chk("mid_vld", 32'(bus.rsp_valid), 32'd0);
    chk("mid_alu_a0", bus.alu_a, 32'd0);
    chk("mid_alu_b0", bus.alu_b, 32'd0);
    chk("mid_aluc0", 32'(bus.alu_aluc), 32'd0);
    chk("mid_s0", bus.rsp_s, 32'd0);
    chk("mid_id0", 32'(bus.rsp_id), 32'd0);
    @(posedge clk);
    #1 clrn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_vld", 32'(bus.rsp_valid), 32'd0);
    end
    drive(1'b0, 1'b1, 4'b0000, 32'd2, 32'd2);
    drive(1'b1, 1'b1, 4'b0000, 32'd9, 32'd9);
    #1;
    chk("tie_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("tie_rdy1", 32'(bus.req1_ready), 32'd0);
    cyc();
    drive(1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 4'h0, 32'd0, 32'd0);
    cyc();
    chk("tie_vld", 32'(bus.rsp_valid), 32'd1);
    chk("tie_id", 32'(bus.rsp_id), 32'd0);
    chk("tie_s", bus.rsp_s, 32'd4);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
